// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared definitions for the FP adder and its result collector.
//                Covers the field widths, the stage and status codes, and the
//                packed result word layout.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W = 6;
    localparam int MAN_W = 25;

    // Adder stage indicator codes
    localparam logic [2:0] STG_READ  = 3'd0;
    localparam logic [2:0] STG_ALIGN = 3'd1;
    localparam logic [2:0] STG_ADD   = 3'd2;
    localparam logic [2:0] STG_NORM  = 3'd3;
    localparam logic [2:0] STG_CHECK = 3'd4;

    // Adder status codes
    localparam logic [3:0] ST_EXACT = 4'd0;
    localparam logic [3:0] ST_OVF   = 4'd1;
    localparam logic [3:0] ST_UNF   = 4'd2;
    localparam logic [3:0] ST_INX   = 4'd3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_word_t;

endpackage
`default_nettype wire

// File: rtl/fp_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fp_result_fifo
//  Description : First-word-fall-through FIFO. rdata always shows the head
//                entry. Occupancy is tracked by a separate counter so the
//                pointers can wrap freely modulo DEPTH.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int         PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together keeps count steady
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : fp_result_collector
//  Description : Captures each finished adder result on entry to the CHECK
//                stage, buffers it behind a valid/ready port, and keeps sticky
//                exception flags plus result and drop counters.
//  Revision    : 1.0  initial release
// ============================================================================
module fp_result_collector
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock_100kHz,
    input  logic             reset,
    input  logic [2:0]       stage_in,
    input  logic [31:0]      data_in,
    input  logic [3:0]       status_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [3:0]       res_status,
    output logic             res_is_zero,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    output logic             sticky_inx,
    input  logic             clear_sticky,
    output logic [CNT_W-1:0] result_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             fifo_full
);

    logic [2:0]  stage_q;
    logic        capture;
    logic        pop;
    logic        push;
    logic        fifo_empty;
    logic [35:0] fifo_rdata;
    fp_word_t    head_word;

    // Rising edge into CHECK: a long dwell in CHECK yields one capture only
    assign capture = (stage_in == STG_CHECK) && (stage_q != STG_CHECK);
    assign pop     = res_valid && res_ready;
    // A full FIFO can still accept when the head leaves in the same cycle
    assign push    = capture && (!fifo_full || pop);

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (36)
    ) u_fifo (
        .clk   (clock_100kHz),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({data_in, status_in}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head outputs are forced to zero while empty so stale storage never leaks
    assign head_word   = fifo_rdata[35:4];
    assign res_valid   = !fifo_empty;
    assign res_data    = res_valid ? head_word : '0;
    assign res_status  = res_valid ? fifo_rdata[3:0] : '0;
    assign res_is_zero = res_valid && (head_word.exp == '0) && (head_word.man == '0);

    // Stage history for the CHECK-entry edge detector
    always_ff @(posedge clock_100kHz) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_in;
        end
    end

    // Capture counter wraps; drop counter saturates at all-ones
    always_ff @(posedge clock_100kHz) begin
        if (reset) begin
            result_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (capture) begin
                result_cnt <= result_cnt + 1'b1;
            end
            if (capture && !push && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Sticky exception flags; a setting capture overrides a coincident clear
    always_ff @(posedge clock_100kHz) begin
        if (reset) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
            sticky_inx <= 1'b0;
        end else begin
            sticky_ovf <= (sticky_ovf && !clear_sticky) || (capture && (status_in == ST_OVF));
            sticky_unf <= (sticky_unf && !clear_sticky) || (capture && (status_in == ST_UNF));
            sticky_inx <= (sticky_inx && !clear_sticky) || (capture && (status_in == ST_INX));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_result_collector
//  Description : Directed self-checking bench for fp_result_collector.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp_result_collector;

    logic        clk;
    logic        reset;
    logic [2:0]  stage_in;
    logic [31:0] data_in;
    logic [3:0]  status_in;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_status;
    logic        res_is_zero;
    logic        sticky_ovf;
    logic        sticky_unf;
    logic        sticky_inx;
    logic        clear_sticky;
    logic [15:0] result_cnt;
    logic [15:0] drop_cnt;
    logic        fifo_full;

    int checks = 0;
    int errors = 0;

    fp_result_collector #(
        .DEPTH (4),
        .CNT_W (16)
    ) dut (
        .clock_100kHz (clk),
        .reset        (reset),
        .stage_in     (stage_in),
        .data_in      (data_in),
        .status_in    (status_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_status   (res_status),
        .res_is_zero  (res_is_zero),
        .sticky_ovf   (sticky_ovf),
        .sticky_unf   (sticky_unf),
        .sticky_inx   (sticky_inx),
        .clear_sticky (clear_sticky),
        .result_cnt   (result_cnt),
        .drop_cnt     (drop_cnt),
        .fifo_full    (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One adder pass ending with the capture edge; rdy/clr apply on that edge
    task automatic adder_pass(input logic [31:0] d, input logic [3:0] s,
                              input logic rdy, input logic clr);
        stage_in = 3'd1; step();
        stage_in = 3'd2; step();
        stage_in = 3'd3; step();
        stage_in = 3'd4; data_in = d; status_in = s;
        res_ready = rdy; clear_sticky = clr;
        step();
        res_ready = 1'b0; clear_sticky = 1'b0;
        stage_in = 3'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1; stage_in = 3'd0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic pop_one();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] drain_exp [4];
        reset = 1'b1; stage_in = 3'd0; data_in = '0; status_in = '0;
        res_ready = 1'b0; clear_sticky = 1'b0;
        step(); step(); step();

        // Reset state
        check("rst_valid",  {31'd0, res_valid}, 32'd0);
        check("rst_data",   res_data, 32'd0);
        check("rst_rcnt",   {16'd0, result_cnt}, 32'd0);
        check("rst_dcnt",   {16'd0, drop_cnt}, 32'd0);
        check("rst_sticky", {29'd0, sticky_ovf, sticky_unf, sticky_inx}, 32'd0);
        check("rst_full",   {31'd0, fifo_full}, 32'd0);
        check("rst_zero",   {31'd0, res_is_zero}, 32'd0);
        reset = 1'b0;
        step();

        // 1: single pass
        adder_pass(32'h4200_0000, 4'd0, 1'b0, 1'b0);
        check("t1_valid",  {31'd0, res_valid}, 32'd1);
        check("t1_data",   res_data, 32'h4200_0000);
        check("t1_status", {28'd0, res_status}, 32'd0);
        check("t1_rcnt",   {16'd0, result_cnt}, 32'd1);
        check("t1_zero",   {31'd0, res_is_zero}, 32'd0);
        pop_one();
        check("t1_popped", {31'd0, res_valid}, 32'd0);

        // 2: CHECK held 5 cycles captures once
        do_reset();
        stage_in = 3'd1; step();
        stage_in = 3'd2; step();
        stage_in = 3'd3; step();
        stage_in = 3'd4; data_in = 32'h3F80_0000; status_in = 4'd3;
        for (int i = 0; i < 5; i++) step();
        stage_in = 3'd0;
        check("t2_rcnt",   {16'd0, result_cnt}, 32'd1);
        check("t2_data",   res_data, 32'h3F80_0000);
        check("t2_status", {28'd0, res_status}, 32'd3);
        pop_one();
        check("t2_single", {31'd0, res_valid}, 32'd0);

        // 3: five passes with no consumer
        do_reset();
        for (int i = 1; i <= 4; i++) adder_pass(32'h1000_0000 + i, 4'd0, 1'b0, 1'b0);
        check("t3_full4",  {31'd0, fifo_full}, 32'd1);
        check("t3_dcnt0",  {16'd0, drop_cnt}, 32'd0);
        adder_pass(32'h1000_0005, 4'd0, 1'b0, 1'b0);
        check("t3_dcnt",   {16'd0, drop_cnt}, 32'd1);
        check("t3_rcnt",   {16'd0, result_cnt}, 32'd5);
        check("t3_head",   res_data, 32'h1000_0001);
        check("t3_full5",  {31'd0, fifo_full}, 32'd1);

        // 4: full + capture + pop together
        adder_pass(32'h1000_0006, 4'd0, 1'b1, 1'b0);
        check("t4_dcnt",   {16'd0, drop_cnt}, 32'd1);
        check("t4_full",   {31'd0, fifo_full}, 32'd1);
        check("t4_head",   res_data, 32'h1000_0002);
        check("t4_rcnt",   {16'd0, result_cnt}, 32'd6);
        drain_exp[0] = 32'h1000_0002; drain_exp[1] = 32'h1000_0003;
        drain_exp[2] = 32'h1000_0004; drain_exp[3] = 32'h1000_0006;
        for (int i = 0; i < 4; i++) begin
            check("t4_drain", res_data, drain_exp[i]);
            pop_one();
        end
        check("t4_empty",  {31'd0, res_valid}, 32'd0);

        // 5: sticky flags
        do_reset();
        adder_pass(32'h0000_0101, 4'd1, 1'b0, 1'b0);
        check("t5_ovf_only", {29'd0, sticky_ovf, sticky_unf, sticky_inx}, 32'b100);
        adder_pass(32'h0000_0102, 4'd2, 1'b0, 1'b0);
        adder_pass(32'h0000_0103, 4'd3, 1'b0, 1'b0);
        check("t5_all",    {29'd0, sticky_ovf, sticky_unf, sticky_inx}, 32'b111);
        clear_sticky = 1'b1; step(); clear_sticky = 1'b0;
        check("t5_clear",  {29'd0, sticky_ovf, sticky_unf, sticky_inx}, 32'b000);
        adder_pass(32'h0000_0104, 4'd2, 1'b0, 1'b0);
        check("t5_unf",    {29'd0, sticky_ovf, sticky_unf, sticky_inx}, 32'b010);
        adder_pass(32'h0000_0105, 4'd1, 1'b0, 1'b1);
        check("t5_setwins", {29'd0, sticky_ovf, sticky_unf, sticky_inx}, 32'b100);
        check("t5_dcnt",   {16'd0, drop_cnt}, 32'd1);
        check("t5_rcnt",   {16'd0, result_cnt}, 32'd5);

        // 6: zero detect and mid-stream reset
        do_reset();
        adder_pass(32'h0000_0000, 4'd0, 1'b0, 1'b0);
        check("t6_zero",   {31'd0, res_is_zero}, 32'd1);
        adder_pass(32'h8000_0000, 4'd0, 1'b0, 1'b0);
        pop_one();
        check("t6_negzero_data", res_data, 32'h8000_0000);
        check("t6_negzero", {31'd0, res_is_zero}, 32'd1);
        adder_pass(32'h0000_0011, 4'd2, 1'b0, 1'b0);
        adder_pass(32'h0000_0022, 4'd0, 1'b0, 1'b0);
        pop_one();
        check("t6_nonzero", {31'd0, res_is_zero}, 32'd0);
        adder_pass(32'h0000_0033, 4'd0, 1'b0, 1'b0);
        check("t6_pre_rcnt", {16'd0, result_cnt}, 32'd5);
        reset = 1'b1; stage_in = 3'd4; data_in = 32'hABCD_0001; status_in = 4'd0;
        step();
        check("t6_rst_valid", {31'd0, res_valid}, 32'd0);
        check("t6_rst_rcnt",  {16'd0, result_cnt}, 32'd0);
        check("t6_rst_sticky", {29'd0, sticky_ovf, sticky_unf, sticky_inx}, 32'd0);
        check("t6_rst_zero",  {31'd0, res_is_zero}, 32'd0);
        reset = 1'b0;
        step();
        stage_in = 3'd0;
        check("t6_post_valid", {31'd0, res_valid}, 32'd1);
        check("t6_post_data",  res_data, 32'hABCD_0001);
        check("t6_post_rcnt",  {16'd0, result_cnt}, 32'd1);
        pop_one();
        check("t6_post_empty", {31'd0, res_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
